// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control unit.
// FSM over a shared memory port and a mul-div unit.
package mc_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALI   = 7'b0010011;
  localparam logic [6:0] OP_ALR   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MD  = 7'b0000001;

  localparam logic PC_PC4  = 1'b0;
  localparam logic PC_ALU  = 1'b1;
  localparam logic M_READ  = 1'b0;
  localparam logic M_WRITE = 1'b1;
  localparam logic A_RS1   = 1'b0;
  localparam logic A_PC    = 1'b1;
  localparam logic B_RS2   = 1'b0;
  localparam logic B_IMM   = 1'b1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_DM  = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_MD  = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    MDWAIT = 3'd5,
    TRAP   = 3'd6
  } state_t;
endpackage

module mc_control
  import mc_pkg::*;
#(
  parameter bit          HAS_MULDIV = 1'b1,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TO_W       = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             brtaken,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic [2:0]       state,
  output logic             ir_wen,
  output logic             pc_wen,
  output logic             pc_sel,
  output logic             reg_wen,
  output logic             mem_req,
  output logic             mem_rw,
  output logic             addr_sel,
  output logic             a_sel,
  output logic             b_sel,
  output logic [1:0]       wb_sel,
  output logic [2:0]       imm_sel,
  output logic [3:0]       alu_sel,
  output logic             mem_sign,
  output logic [1:0]       mem_len,
  output logic [2:0]       br_sel,
  output logic             md_start,
  output logic [2:0]       md_op,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  state_t          st, nxt;
  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic            md_q;
  logic [TO_W-1:0] to_cnt;
  logic            to_lim, retire;
  logic            ill, dec_a, dec_b, dec_md;
  logic [1:0]      dec_wb;
  logic [2:0]      dec_imm;
  logic [3:0]      dec_alu;
  logic            is_ld, is_st, is_br, is_jmp;

  assign state    = st;
  assign mem_sign = f3_q[2];
  assign mem_len  = f3_q[1:0];
  assign br_sel   = f3_q;
  assign md_op    = f3_q;
  assign is_ld    = (op_q == OP_LOAD);
  assign is_st    = (op_q == OP_STORE);
  assign is_br    = (op_q == OP_BR);
  assign is_jmp   = (op_q == OP_JAL) || (op_q == OP_JALR);
  assign to_lim   = (TIMEOUT != 0) &&
                    (to_cnt == TO_W'(TIMEOUT - 1));

  // Decode the live IR fields and flag illegal encodings.
  always_comb begin
    ill     = 1'b0;
    dec_a   = A_RS1;
    dec_b   = B_IMM;
    dec_md  = 1'b0;
    dec_wb  = WB_ALU;
    dec_imm = IMM_I;
    dec_alu = ALU_ADD;
    unique case (opcode)
      OP_LOAD:  dec_wb = WB_DM;
      OP_STORE: dec_imm = IMM_S;
      OP_ALI: begin
        if (funct3 == 3'b101) begin
          dec_alu = {funct7[5], funct3};
          ill = (funct7 != F7_0) && (funct7 != F7_ALT);
        end else begin
          dec_alu = {1'b0, funct3};
          ill = (funct3 == 3'b001) && (funct7 != F7_0);
        end
      end
      OP_ALR: begin
        dec_b   = B_RS2;
        dec_alu = {funct7[5], funct3};
        dec_md  = HAS_MULDIV && (funct7 == F7_MD);
        if (dec_md) dec_wb = WB_MD;
        ill = !((funct7 == F7_0) || dec_md ||
                ((funct7 == F7_ALT) &&
                 ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_BR: begin
        dec_a   = A_PC;
        dec_imm = IMM_B;
        ill     = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        dec_a   = A_PC;
        dec_imm = IMM_J;
        dec_wb  = WB_PC4;
      end
      OP_JALR: begin
        dec_wb = WB_PC4;
        ill    = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec_imm = IMM_U;
        dec_alu = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec_a   = A_PC;
        dec_imm = IMM_U;
      end
      default: ill = 1'b1;
    endcase
  end

  // Next state and strobes; everything is quiet while in reset.
  always_comb begin
    nxt      = st;
    retire   = 1'b0;
    ir_wen   = 1'b0;
    pc_wen   = 1'b0;
    pc_sel   = PC_PC4;
    reg_wen  = 1'b0;
    mem_req  = 1'b0;
    mem_rw   = M_READ;
    addr_sel = 1'b0;
    md_start = 1'b0;
    if (rst_n) begin
      unique case (st)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_wen = 1'b1;
            nxt    = DECODE;
          end else if (to_lim) begin
            nxt = TRAP;
          end
        end
        DECODE: nxt = ill ? TRAP : EXEC;
        EXEC: begin
          unique case (1'b1)
            is_ld || is_st: nxt = MEM;
            md_q: begin
              md_start = 1'b1;
              nxt      = MDWAIT;
            end
            is_br: begin
              pc_wen = 1'b1;
              pc_sel = brtaken ? PC_ALU : PC_PC4;
              retire = 1'b1;
              nxt    = FETCH;
            end
            default: nxt = WB;
          endcase
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_rw   = is_st ? M_WRITE : M_READ;
          if (mem_ready) begin
            if (is_st) begin
              pc_wen = 1'b1;
              retire = 1'b1;
              nxt    = FETCH;
            end else begin
              nxt = WB;
            end
          end else if (to_lim) begin
            nxt = TRAP;
          end
        end
        MDWAIT: if (md_done) nxt = WB;
        WB: begin
          reg_wen = 1'b1;
          pc_wen  = 1'b1;
          pc_sel  = is_jmp ? PC_ALU : PC_PC4;
          retire  = 1'b1;
          nxt     = FETCH;
        end
        TRAP:    nxt = TRAP;
        default: nxt = FETCH;
      endcase
    end
  end

  // State, latched decode, timeout, trap and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= FETCH;
      op_q       <= '0;
      f3_q       <= '0;
      md_q       <= 1'b0;
      a_sel      <= 1'b0;
      b_sel      <= 1'b0;
      wb_sel     <= '0;
      imm_sel    <= '0;
      alu_sel    <= '0;
      to_cnt     <= '0;
      trap       <= 1'b0;
      trap_cause <= '0;
      instret    <= '0;
    end else begin
      st <= nxt;
      if (nxt != st) to_cnt <= '0;
      else if (mem_req && !mem_ready) to_cnt <= to_cnt + 1'b1;
      if (retire) instret <= instret + 1'b1;
      if ((nxt == TRAP) && (st != TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= (st == DECODE) ? 2'd1 : 2'd2;
      end
      if ((st == DECODE) && !ill) begin
        op_q    <= opcode;
        f3_q    <= funct3;
        md_q    <= dec_md;
        a_sel   <= dec_a;
        b_sel   <= dec_b;
        wb_sel  <= dec_wb;
        imm_sel <= dec_imm;
        alu_sel <= dec_alu;
      end
    end
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed vectors and hand-built
// multi-cycle sequences for mc_control.
`timescale 1ns/1ps
module tb_mc_control;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        brtaken, mem_ready, md_done;
  logic [2:0]  state, imm_sel, br_sel, md_op;
  logic        ir_wen, pc_wen, pc_sel, reg_wen, mem_req, mem_rw;
  logic        addr_sel, a_sel, b_sel, mem_sign, md_start, trap;
  logic [1:0]  wb_sel, mem_len, trap_cause;
  logic [3:0]  alu_sel;
  logic [31:0] instret;

  logic [2:0]  b_state, b_imm_sel, b_br_sel, b_md_op;
  logic        b_ir_wen, b_pc_wen, b_pc_sel, b_reg_wen, b_mem_req;
  logic        b_mem_rw, b_addr_sel, b_a_sel, b_b_sel, b_mem_sign;
  logic        b_md_start, b_trap;
  logic [1:0]  b_wb_sel, b_mem_len, b_trap_cause;
  logic [3:0]  b_alu_sel;
  logic [7:0]  b_instret;

  int n_tests, n_fail, exp_ir;

  always #5 clk = ~clk;

  mc_control #(
    .HAS_MULDIV(1'b1), .TIMEOUT(4), .TO_W(8), .CNT_W(32)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .brtaken(brtaken), .mem_ready(mem_ready),
    .md_done(md_done), .state(state), .ir_wen(ir_wen),
    .pc_wen(pc_wen), .pc_sel(pc_sel), .reg_wen(reg_wen),
    .mem_req(mem_req), .mem_rw(mem_rw), .addr_sel(addr_sel),
    .a_sel(a_sel), .b_sel(b_sel), .wb_sel(wb_sel),
    .imm_sel(imm_sel), .alu_sel(alu_sel), .mem_sign(mem_sign),
    .mem_len(mem_len), .br_sel(br_sel), .md_start(md_start),
    .md_op(md_op), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  mc_control #(
    .HAS_MULDIV(1'b0), .TIMEOUT(0), .TO_W(8), .CNT_W(8)
  ) u_nomd (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .brtaken(brtaken), .mem_ready(mem_ready),
    .md_done(md_done), .state(b_state), .ir_wen(b_ir_wen),
    .pc_wen(b_pc_wen), .pc_sel(b_pc_sel), .reg_wen(b_reg_wen),
    .mem_req(b_mem_req), .mem_rw(b_mem_rw), .addr_sel(b_addr_sel),
    .a_sel(b_a_sel), .b_sel(b_b_sel), .wb_sel(b_wb_sel),
    .imm_sel(b_imm_sel), .alu_sel(b_alu_sel),
    .mem_sign(b_mem_sign), .mem_len(b_mem_len),
    .br_sel(b_br_sel), .md_start(b_md_start), .md_op(b_md_op),
    .trap(b_trap), .trap_cause(b_trap_cause),
    .instret(b_instret)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       br;
    int         cyc;
    logic       ill;
    logic [3:0] alu;
    logic [1:0] wb;
    logic [2:0] imm;
    logic       a;
    logic       b;
    logic       psel;
    int         nrw;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  function automatic vec_t mk(
    input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic br, input int cyc,
    input logic ill, input logic [3:0] alu,
    input logic [1:0] wb, input logic [2:0] imm,
    input logic a, input logic b, input logic psel,
    input int nrw);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.br = br;
    v.cyc = cyc; v.ill = ill; v.alu = alu; v.wb = wb;
    v.imm = imm; v.a = a; v.b = b; v.psel = psel;
    v.nrw = nrw;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h expected %0h",
               nm, idx, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    md_done = 1'b1;
    brtaken = 1'b0;
    #1;
    chk("reset_ctl", 0,
        {state, ir_wen, pc_wen, pc_sel, reg_wen, mem_req,
         mem_rw, addr_sel, md_start, trap, trap_cause}, 0);
    chk("reset_sel", 0,
        {a_sel, b_sel, wb_sel, imm_sel, alu_sel, mem_sign,
         mem_len, br_sel, md_op}, 0);
    chk("reset_cnt", 0, instret, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, npc, nrw;
    logic psel;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    brtaken = v.br; mem_ready = 1'b1; md_done = 1'b1;
    cyc = 0; npc = 0; nrw = 0; psel = 1'b0;
    do begin
      #1;
      if (pc_wen) begin
        npc++;
        psel = pc_sel;
      end
      if (reg_wen) nrw++;
      cyc++;
      cycle();
    end while (state != 3'd0 && state != 3'd6 && cyc < 40);
    chk("cycles", idx, cyc, v.cyc);
    if (v.ill) begin
      #1;
      chk("ill_trap", idx, {trap, trap_cause, state},
          {1'b1, 2'd1, 3'd6});
      chk("ill_pcwen", idx, npc, 0);
      chk("ill_instret", idx, instret, exp_ir);
      chk("ill_quiet", idx,
          {ir_wen, pc_wen, reg_wen, mem_req, md_start}, 0);
      do_reset();
      exp_ir = 0;
    end else begin
      exp_ir++;
      chk("instret", idx, instret, exp_ir);
      chk("pc_wen_cnt", idx, npc, 1);
      chk("pc_sel", idx, psel, v.psel);
      chk("reg_wen_cnt", idx, nrw, v.nrw);
      chk("alu_sel", idx, alu_sel, v.alu);
      chk("sels", idx, {a_sel, b_sel, wb_sel, imm_sel},
          {v.a, v.b, v.wb, v.imm});
      chk("f3_latch", idx, {mem_sign, mem_len, br_sel, md_op},
          {v.f3, v.f3, v.f3});
      if (v.op == 7'b0110011 && v.f7 == 7'b0000001)
        chk("nomd_trap", idx, {b_trap, b_trap_cause},
            {1'b1, 2'd1});
    end
  endtask

  task automatic seq_addi();
    logic [2:0] es[4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    do_reset();
    opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'd0;
    mem_ready = 1'b1; md_done = 1'b0;
    chk("addi_ir0", 0, instret, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("addi_state", c, state, es[c]);
      chk("addi_rwen", c, reg_wen, (c == 3));
      cycle();
    end
    chk("addi_end", 0, state, 0);
    chk("addi_ir1", 0, instret, 1);
  endtask

  task automatic seq_load();
    logic [2:0] es[8] = '{3'd0, 3'd1, 3'd2, 3'd3,
                          3'd3, 3'd3, 3'd3, 3'd4};
    logic       mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                          1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] em[8] = '{3'b100, 3'b000, 3'b000, 3'b110,
                          3'b110, 3'b110, 3'b110, 3'b000};
    do_reset();
    opcode = 7'b0000011; funct3 = 3'b101; funct7 = 7'd0;
    md_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = mr[c];
      #1;
      chk("ld_state", c, state, es[c]);
      chk("ld_mem", c, {mem_req, addr_sel, mem_rw}, em[c]);
      chk("ld_rwen", c, reg_wen, (c == 7));
      cycle();
    end
    chk("ld_end", 0, {state, trap}, 0);
    chk("ld_ir", 0, instret, 1);
    chk("ld_len", 0, {mem_sign, mem_len}, 3'b101);
  endtask

  task automatic seq_timeout();
    do_reset();
    opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'd0;
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("to_fetch", c, {state, mem_req, ir_wen},
          {3'd0, 1'b1, 1'b0});
      cycle();
    end
    #1;
    chk("to_trap", 0, {trap, trap_cause, state},
        {1'b1, 2'd2, 3'd6});
    chk("to_quiet", 0, {mem_req, ir_wen, pc_wen}, 0);
    repeat (20) cycle();
    #1;
    chk("to_disabled", 0, {b_state, b_mem_req, b_trap},
        {3'd0, 1'b1, 1'b0});
    chk("to_sticky", 0, {trap, state}, {1'b1, 3'd6});
    do_reset();
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("toe_fetch", c, {state, ir_wen}, 0);
      cycle();
    end
    mem_ready = 1'b1;
    #1;
    chk("toe_irwen", 0, ir_wen, 1);
    cycle();
    #1;
    chk("toe_state", 0, {trap, state}, {1'b0, 3'd1});
  endtask

  task automatic seq_mul();
    int         cyc, nst, mdc;
    logic [1:0] wbs;
    do_reset();
    opcode = 7'b0110011; funct3 = 3'b011; funct7 = 7'b0000001;
    mem_ready = 1'b1;
    cyc = 0; nst = 0; mdc = 0; wbs = 2'd0;
    do begin
      md_done = (state == 3'd5) && (mdc == 5);
      #1;
      if (md_start) nst++;
      if (state == 3'd5) mdc++;
      if (state == 3'd4) wbs = wb_sel;
      cyc++;
      cycle();
    end while (state != 3'd0 && state != 3'd6 && cyc < 40);
    md_done = 1'b0;
    chk("mul_cycles", 0, cyc, 10);
    chk("mul_wait", 0, mdc, 6);
    chk("mul_start", 0, nst, 1);
    chk("mul_wb", 0, wbs, 2'd3);
    chk("mul_op", 0, md_op, 3'b011);
    chk("mul_ir", 0, instret, 1);
    chk("mul_nomd", 0, {b_trap, b_trap_cause, b_state},
        {1'b1, 2'd1, 3'd6});
  endtask

  task automatic seq_rst_mem();
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0;
    mem_ready = 1'b1; md_done = 1'b0;
    cycle();
    cycle();
    cycle();
    mem_ready = 1'b0;
    cycle();
    #1;
    chk("rm_in_mem", 0, {state, mem_req}, {3'd3, 1'b1});
    chk("rm_ir", 0, instret, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_async", 0,
        {state, mem_req, addr_sel, pc_wen, reg_wen, ir_wen}, 0);
    chk("rm_ir0", 0, instret, 0);
    mem_ready = 1'b1;
    #1;
    chk("rm_gated", 0, {ir_wen, mem_req, pc_wen}, 0);
    do_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_ir = 0;
    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    brtaken = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
    vt[0]  = mk(7'b0010011, 3'b000, 7'b0000000, 0, 4, 0,
                4'b0000, 2'd0, 3'd0, 0, 1, 0, 1);
    vt[1]  = mk(7'b0010011, 3'b000, 7'b0100000, 0, 4, 0,
                4'b0000, 2'd0, 3'd0, 0, 1, 0, 1);
    vt[2]  = mk(7'b0010011, 3'b101, 7'b0100000, 0, 4, 0,
                4'b1101, 2'd0, 3'd0, 0, 1, 0, 1);
    vt[3]  = mk(7'b0010011, 3'b101, 7'b0000000, 0, 4, 0,
                4'b0101, 2'd0, 3'd0, 0, 1, 0, 1);
    vt[4]  = mk(7'b0010011, 3'b001, 7'b0000000, 0, 4, 0,
                4'b0001, 2'd0, 3'd0, 0, 1, 0, 1);
    vt[5]  = mk(7'b0110011, 3'b000, 7'b0100000, 0, 4, 0,
                4'b1000, 2'd0, 3'd0, 0, 0, 0, 1);
    vt[6]  = mk(7'b0110011, 3'b101, 7'b0100000, 0, 4, 0,
                4'b1101, 2'd0, 3'd0, 0, 0, 0, 1);
    vt[7]  = mk(7'b0110011, 3'b000, 7'b0000001, 0, 5, 0,
                4'b0000, 2'd3, 3'd0, 0, 0, 0, 1);
    vt[8]  = mk(7'b0000011, 3'b010, 7'b0000000, 0, 5, 0,
                4'b0000, 2'd1, 3'd0, 0, 1, 0, 1);
    vt[9]  = mk(7'b0100011, 3'b010, 7'b0000000, 0, 4, 0,
                4'b0000, 2'd0, 3'd1, 0, 1, 0, 0);
    vt[10] = mk(7'b1100011, 3'b000, 7'b0000000, 1, 3, 0,
                4'b0000, 2'd0, 3'd2, 1, 1, 1, 0);
    vt[11] = mk(7'b1100011, 3'b001, 7'b0000000, 0, 3, 0,
                4'b0000, 2'd0, 3'd2, 1, 1, 0, 0);
    vt[12] = mk(7'b1101111, 3'b000, 7'b0000000, 0, 4, 0,
                4'b0000, 2'd2, 3'd4, 1, 1, 1, 1);
    vt[13] = mk(7'b1100111, 3'b000, 7'b0000000, 0, 4, 0,
                4'b0000, 2'd2, 3'd0, 0, 1, 1, 1);
    vt[14] = mk(7'b0110111, 3'b000, 7'b0000000, 0, 4, 0,
                4'b1111, 2'd0, 3'd3, 0, 1, 0, 1);
    vt[15] = mk(7'b0010111, 3'b000, 7'b0000000, 0, 4, 0,
                4'b0000, 2'd0, 3'd3, 1, 1, 0, 1);
    vt[16] = mk(7'b0010011, 3'b101, 7'b0000001, 0, 2, 1,
                4'b0000, 2'd0, 3'd0, 0, 0, 0, 0);
    vt[17] = mk(7'b1111111, 3'b000, 7'b0000000, 0, 2, 1,
                4'b0000, 2'd0, 3'd0, 0, 0, 0, 0);
    vt[18] = mk(7'b1100111, 3'b001, 7'b0000000, 0, 2, 1,
                4'b0000, 2'd0, 3'd0, 0, 0, 0, 0);
    vt[19] = mk(7'b1100011, 3'b010, 7'b0000000, 0, 2, 1,
                4'b0000, 2'd0, 3'd0, 0, 0, 0, 0);
    vt[20] = mk(7'b0110011, 3'b001, 7'b0100000, 0, 2, 1,
                4'b0000, 2'd0, 3'd0, 0, 0, 0, 0);
    vt[21] = mk(7'b0010011, 3'b001, 7'b0100000, 0, 2, 1,
                4'b0000, 2'd0, 3'd0, 0, 0, 0, 0);
    vt[22] = mk(7'b0110011, 3'b000, 7'b0000010, 0, 2, 1,
                4'b0000, 2'd0, 3'd0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < NV; i++) run_vec(vt[i], i);
    seq_addi();
    seq_load();
    seq_timeout();
    seq_mul();
    seq_rst_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle RV32I control unit with optional M-extension sequencing; next generation of the single-cycle decoder.
- Sequences FETCH/DECODE/EXEC/MEM/MDWAIT/WB over a shared ready-handshaked memory port and a start/done mul-div unit.
- Detects illegal encodings and memory timeouts; counts retired instructions.
- Sits between the IR/datapath registers and the unified memory interface of the multi-cycle core.

Parameters:
HAS_MULDIV, 1, 1 accepts funct7=0000001 on OP_ALR and drives the mul-div unit; 0 treats it as illegal
TIMEOUT, 255, max mem_ready wait cycles per access; 0 disables timeout
TO_W, 8, timeout counter width, must satisfy 2^TO_W > TIMEOUT
CNT_W, 32, instret counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
opcode  in  7  IR[6:0], valid from DECODE onward
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
brtaken  in  1  branch comparator result, sampled in EXEC
mem_ready  in  1  memory completes the access this cycle; ignored when mem_req=0
md_done  in  1  mul-div result valid; ignored outside MDWAIT
state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 MDWAIT=5 TRAP=6
ir_wen  out  1  IR load strobe
pc_wen  out  1  PC load strobe
pc_sel  out  1  `PC_PC4/`PC_ALU
reg_wen  out  1  register-file write strobe
mem_req  out  1  memory request
mem_rw  out  1  `M_READ/`M_WRITE
addr_sel  out  1  0=PC, 1=ALU result
a_sel, b_sel  out  1 each  ALU operand selects (`A_*, `B_*)
wb_sel  out  2  `WB_ALU/`WB_DM/`WB_PC4/2'b11=mul-div result
imm_sel  out  3  `IMM_* immediate format
alu_sel  out  4  ALU operation
mem_sign  out  1  funct3[2] (latched)
mem_len  out  2  funct3[1:0] (latched)
br_sel  out  3  funct3 (latched)
md_start  out  1  one-cycle mul-div start pulse
md_op  out  3  funct3 (latched)
trap  out  1  sticky trap flag
trap_cause  out  2  0=none 1=illegal 2=bus timeout
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async): state=FETCH; instret=0; trap=0; trap_cause=0; timeout counter=0; all strobes and selects 0.
- Strobes (ir_wen, pc_wen, reg_wen, mem_req, md_start) are combinational from the state and latched fields.
- Decode fields are registered on the DECODE->EXEC transition and held until retire.
- Decode rules:
  - OP_ALI funct3=101: alu_sel={funct7[5],101} (fixes SRAI).
  - OP_ALI other funct3: alu_sel={0,funct3}.
  - OP_ALR: alu_sel={funct7[5],funct3}.
  - LUI: alu_sel=`ALU_PASSB. All other opcodes: alu_sel=`ALU_ADD.
- Illegal (checked in DECODE):
  - opcode not among the 9 RV32I classes.
  - ALR funct7 not in {0000000, 0100000, 0000001 when HAS_MULDIV}, or 0100000 with funct3 not in {000, 101}.
  - ALI funct3=001 with funct7!=0, or funct3=101 with funct7 not in {0000000, 0100000}.
  - JALR funct3!=0; BRANCH funct3 in {010, 011}.
- FETCH: mem_req=1, mem_rw=READ, addr_sel=0. On mem_ready: ir_wen=1 that cycle, ->DECODE.
- DECODE: illegal ->TRAP with cause 1; otherwise ->EXEC.
- EXEC, by opcode:
  - LOAD/STORE ->MEM.
  - Mul-div: md_start=1 for one cycle, ->MDWAIT.
  - BRANCH: pc_wen=1, pc_sel=brtaken?ALU:PC4; retire; ->FETCH.
  - Others ->WB.
- MEM: mem_req=1, addr_sel=1, mem_rw per opcode. On mem_ready:
  - STORE: pc_wen=1 (PC4), retire, ->FETCH.
  - LOAD ->WB.
- MDWAIT: on md_done ->WB. No timeout.
- WB: reg_wen=1, pc_wen=1, pc_sel=ALU for JAL/JALR else PC4; retire; ->FETCH.
- Retire: instret+1, wraps to 0 after 2^CNT_W-1. Exactly one pc_wen pulse per instruction.
- Latency with zero-wait memory: BRANCH 3 cycles; STORE, ALU, jump and U-type 4; LOAD 5; mul-div 5+unit latency.
- Timeout counter:
  - Clears on entering FETCH or MEM.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Reaching TIMEOUT with TIMEOUT!=0 ->TRAP with cause 2; no ir_wen or pc_wen that cycle.
  - mem_ready in the same cycle as the limit wins (access completes).
- TRAP: sticky until reset. trap=1; all strobes 0; inputs ignored.
- Reset mid-access drops mem_req immediately; no partial retire is counted.

Test Plan:
- ADDI with mem_ready=1 every cycle -> states 0,1,2,4,0; reg_wen high only in WB; instret 0->1 after 4 cycles.
- SRAI (funct3=101, funct7=0100000) -> alu_sel=4'b1101; with funct7=0000001 -> TRAP, trap_cause=1, instret unchanged.
- BEQ with brtaken=1, then brtaken=0 -> pc_wen in EXEC with pc_sel=`PC_ALU then `PC_PC4; 3 cycles each; no reg_wen.
- LOAD with mem_ready withheld 3 cycles in MEM -> MEM held 4 cycles; WB follows; total 8 cycles.
- TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles, trap_cause=2. Repeat with mem_ready rising exactly on cycle 4 -> no trap.
- MUL with HAS_MULDIV=1, md_done after 6 cycles -> single md_start pulse, wb_sel=2'b11 in WB. With HAS_MULDIV=0 -> illegal trap.
- rst_n asserted mid-MEM -> state=0 and all strobes 0 asynchronously; instret=0.
